// File: rtl/multi_cycle_issue_arbiter_pkg.sv
// Shared types and latency constants for the issue arbiter and the execute stages.
package multi_cycle_issue_arbiter_pkg;
  localparam int THREADS_PER_CORE = 4;
  localparam int MC_LATENCY       = 5;
  localparam int SC_LATENCY       = 1;
  localparam int SUBCYCLE_W       = 4;

  typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
  typedef logic [SUBCYCLE_W-1:0]               subcycle_t;

  typedef enum logic {
    ARBITRATE = 1'b0,
    SEQUENCE  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/multi_cycle_issue_arbiter_if.sv
// Thread-select to issue-arbiter bundle; master drives requests, slave is the arbiter.
interface multi_cycle_issue_arbiter_if;
  import multi_cycle_issue_arbiter_pkg::*;

  logic [THREADS_PER_CORE-1:0]   ts_request;
  logic [THREADS_PER_CORE-1:0]   ts_multi_cycle;
  subcycle_t [THREADS_PER_CORE-1:0] ts_subcycles;
  logic                          rollback_en;
  thread_idx_t                   rollback_thread_idx;

  // issue_valid qualifies every issue_* field in the same cycle; the execute
  // pipelines always accept, so there is no ready and nothing is held over.
  logic                          issue_valid;
  thread_idx_t                   issue_thread_idx;
  logic                          issue_multi_cycle;
  subcycle_t                     issue_subcycle;
  logic                          mc_busy;

  modport master (
    output ts_request, ts_multi_cycle, ts_subcycles, rollback_en, rollback_thread_idx,
    input  issue_valid, issue_thread_idx, issue_multi_cycle, issue_subcycle, mc_busy
  );

  modport slave (
    input  ts_request, ts_multi_cycle, ts_subcycles, rollback_en, rollback_thread_idx,
    output issue_valid, issue_thread_idx, issue_multi_cycle, issue_subcycle, mc_busy
  );
endinterface

// File: rtl/multi_cycle_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr, pointer advances past the winner.
module multi_cycle_issue_arbiter_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] request,
  input  logic             update_en,
  output logic [WIDTH-1:0] grant
);
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % WIDTH);
      if (!found && request[idx]) begin
        found      = 1'b1;
        winner     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (update_en && found) begin
      rr_ptr <= (int'(winner) == WIDTH - 1) ? '0 : winner + 1'b1;
    end
  end
endmodule

// File: rtl/multi_cycle_issue_arbiter.sv
// Per-cycle thread issue arbiter with multi-cycle subcycle sequencing.
// Optional MC_WRITEBACK_RESERVE_EN adds the writeback-slot reservation that blocks colliding single-cycle issues.
module multi_cycle_issue_arbiter #(
  parameter int THREADS    = multi_cycle_issue_arbiter_pkg::THREADS_PER_CORE,
  parameter int MC_LATENCY = multi_cycle_issue_arbiter_pkg::MC_LATENCY,
  parameter int SC_LATENCY = multi_cycle_issue_arbiter_pkg::SC_LATENCY
) (
  input  logic                                     clk,
  input  logic                                     reset,
  multi_cycle_issue_arbiter_if.slave               bus,
  output multi_cycle_issue_arbiter_pkg::arb_state_t dbg_state
);
  import multi_cycle_issue_arbiter_pkg::*;

  if (SC_LATENCY < 1 || SC_LATENCY >= MC_LATENCY || THREADS != THREADS_PER_CORE) begin : g_param_check
    $error("multi_cycle_issue_arbiter: need 1 <= SC_LATENCY < MC_LATENCY and THREADS == THREADS_PER_CORE");
  end

  arb_state_t          state, state_nxt;
  thread_idx_t         lock_thread, lock_thread_nxt;
  subcycle_t           counter, counter_nxt;
  subcycle_t           sub_count, sub_count_nxt;
  logic [MC_LATENCY:1] mc_pend, mc_pend_nxt;
  logic [THREADS-1:0]  eligible, grant;
  logic                sc_blocked;
  logic                arb_update;
  thread_idx_t         winner;
  logic                issue_valid, issue_mc;
  thread_idx_t         issue_idx;
  subcycle_t           issue_sub;

`ifdef MC_WRITEBACK_RESERVE_EN
  logic [MC_LATENCY:1] wb_res, wb_res_nxt;

  // Bit SC_LATENCY of the shifted vector: a multi-cycle result lands in the slot we would take.
  assign sc_blocked = wb_res[SC_LATENCY+1];

  always_comb begin
    wb_res_nxt = wb_res >> 1;
    if (issue_valid) begin
      if (issue_mc) wb_res_nxt[MC_LATENCY] = 1'b1;
      else          wb_res_nxt[SC_LATENCY] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wb_res <= '0;
    else        wb_res <= wb_res_nxt;
  end
`else
  assign sc_blocked = 1'b0;
`endif

  always_comb begin
    eligible = '0;
    for (int t = 0; t < THREADS; t++) begin
      eligible[t] = bus.ts_request[t]
                 && !(bus.rollback_en && int'(bus.rollback_thread_idx) == t)
                 && (bus.ts_multi_cycle[t] || !sc_blocked);
    end
  end

  multi_cycle_issue_arbiter_rr_arbiter #(.WIDTH(THREADS)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .request   (eligible),
    .update_en (arb_update),
    .grant     (grant)
  );

  always_comb begin
    winner = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (grant[t]) winner = thread_idx_t'(t);
    end
  end

  always_comb begin
    state_nxt       = state;
    lock_thread_nxt = lock_thread;
    counter_nxt     = counter;
    sub_count_nxt   = sub_count;
    arb_update      = 1'b0;
    issue_valid     = 1'b0;
    issue_idx       = '0;
    issue_mc        = 1'b0;
    issue_sub       = '0;
    case (state)
      ARBITRATE: begin
        arb_update = 1'b1;
        if (|grant) begin
          issue_valid = 1'b1;
          issue_idx   = winner;
          issue_mc    = bus.ts_multi_cycle[winner];
          if (issue_mc && bus.ts_subcycles[winner] != '0) begin
            state_nxt       = SEQUENCE;
            lock_thread_nxt = winner;
            sub_count_nxt   = bus.ts_subcycles[winner];
            counter_nxt     = subcycle_t'(1);
          end
        end
      end
      SEQUENCE: begin
        // A rollback of the locked thread abandons the rest of the operation.
        if (bus.rollback_en && bus.rollback_thread_idx == lock_thread) begin
          state_nxt = ARBITRATE;
        end else begin
          issue_valid = 1'b1;
          issue_idx   = lock_thread;
          issue_mc    = 1'b1;
          issue_sub   = counter;
          if (counter == sub_count) state_nxt   = ARBITRATE;
          else                      counter_nxt = counter + 1'b1;
        end
      end
      default: state_nxt = ARBITRATE;
    endcase
  end

  always_comb begin
    mc_pend_nxt = mc_pend >> 1;
    if (issue_valid && issue_mc) mc_pend_nxt[MC_LATENCY] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARBITRATE;
      lock_thread <= '0;
      counter     <= '0;
      sub_count   <= '0;
      mc_pend     <= '0;
    end else begin
      state       <= state_nxt;
      lock_thread <= lock_thread_nxt;
      counter     <= counter_nxt;
      sub_count   <= sub_count_nxt;
      mc_pend     <= mc_pend_nxt;
    end
  end

  // Issue outputs are combinational, so they are forced low while reset is held.
  assign bus.issue_valid       = reset & issue_valid;
  assign bus.issue_thread_idx  = reset ? issue_idx : '0;
  assign bus.issue_multi_cycle = reset & issue_mc;
  assign bus.issue_subcycle    = reset ? issue_sub : '0;
  assign bus.mc_busy           = |mc_pend;
  assign dbg_state             = state;
endmodule

// File: tb/tb_multi_cycle_issue_arbiter.sv
// Bench for multi_cycle_issue_arbiter: vector table, directed corner sequences, random run against a model.
module tb_multi_cycle_issue_arbiter;
  import multi_cycle_issue_arbiter_pkg::*;

  localparam int NT = THREADS_PER_CORE;

  logic       clk = 1'b0;
  logic       reset;
  arb_state_t dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  multi_cycle_issue_arbiter_if bus();

  multi_cycle_issue_arbiter #(
    .THREADS(NT), .MC_LATENCY(MC_LATENCY), .SC_LATENCY(SC_LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] req, input logic [3:0] mc, input logic [15:0] subs,
                       input logic rb_en, input logic [1:0] rb_idx);
    bus.ts_request          = req;
    bus.ts_multi_cycle      = mc;
    bus.ts_subcycles        = subs;
    bus.rollback_en         = rb_en;
    bus.rollback_thread_idx = rb_idx;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'h0, 4'h0, 16'h0, 1'b0, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_issue(input string name, input logic v, input logic [1:0] idx,
                             input logic mc, input logic [3:0] sub);
    check({name, " valid"}, 32'(bus.issue_valid), 32'(v));
    check({name, " thread"}, 32'(bus.issue_thread_idx), 32'(idx));
    check({name, " mc"}, 32'(bus.issue_multi_cycle), 32'(mc));
    check({name, " subcycle"}, 32'(bus.issue_subcycle), 32'(sub));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  mc;
    logic [15:0] subs;
    logic        rb_en;
    logic [1:0]  rb_idx;
    logic        exp_v;
    logic [1:0]  exp_idx;
    logic        exp_mc;
    logic [3:0]  exp_sub;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] mc, input logic [15:0] subs,
                              input logic rb_en, input logic [1:0] rb_idx, input logic v,
                              input logic [1:0] idx, input logic emc, input logic [3:0] sub);
    vec_t r;
    r.req = req; r.mc = mc; r.subs = subs; r.rb_en = rb_en; r.rb_idx = rb_idx;
    r.exp_v = v; r.exp_idx = idx; r.exp_mc = emc; r.exp_sub = sub;
    return r;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [8:0] exp_q[$];
  int         m_wb_q[$];
  bit         m_in_seq;
  int         m_ptr, m_lock, m_next, m_last, m_last_mc;

  function automatic void model_reset();
    m_in_seq  = 1'b0;
    m_ptr     = 0;
    m_lock    = 0;
    m_next    = 0;
    m_last    = 0;
    m_last_mc = -1000;
    m_wb_q.delete();
    exp_q.delete();
  endfunction

  // True when some multi-cycle result is due back in writeback cycle wb.
  function automatic bit slot_taken(input int wb);
`ifdef MC_WRITEBACK_RESERVE_EN
    foreach (m_wb_q[i]) if (m_wb_q[i] == wb) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic void model_step(input int cyc, input logic [3:0] req, input logic [3:0] mc,
                                     input logic [15:0] subs, input logic rb_en, input logic [1:0] rb_idx);
    logic v, emc, busy;
    int   idx, sub, t;
    v = 1'b0; emc = 1'b0; idx = 0; sub = 0; t = 0;
    busy = (cyc - m_last_mc >= 1) && (cyc - m_last_mc <= MC_LATENCY);
    if (m_in_seq) begin
      if (rb_en && int'(rb_idx) == m_lock) begin
        m_in_seq = 1'b0;
      end else begin
        v = 1'b1; idx = m_lock; emc = 1'b1; sub = m_next;
        if (m_next == m_last) m_in_seq = 1'b0;
        else                  m_next++;
      end
    end else begin
      for (int k = 0; k < NT; k++) begin
        t = (m_ptr + k) % NT;
        if (!v && req[t] && !(rb_en && int'(rb_idx) == t) &&
            (mc[t] || !slot_taken(cyc + SC_LATENCY))) begin
          v = 1'b1; idx = t; emc = mc[t];
          if (mc[t] && subs[4*t +: 4] != 4'd0) begin
            m_in_seq = 1'b1; m_lock = t; m_next = 1; m_last = int'(subs[4*t +: 4]);
          end
        end
      end
      if (v) m_ptr = (idx + 1) % NT;
    end
    if (v && emc) begin
      m_wb_q.push_back(cyc + MC_LATENCY);
      m_last_mc = cyc;
    end
    exp_q.push_back({v, 2'(idx), emc, 4'(sub), busy});
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [3:0]  r_req, r_mc;
    logic [15:0] r_subs;
    logic        r_rb;
    logic [1:0]  r_rbi;
    logic [8:0]  e;

    vecs[0]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 1, 0, 0);
    vecs[2]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 2, 0, 0);
    vecs[3]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 3, 0, 0);
    vecs[4]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 1, 0, 0);
    vecs[6]  = mk(4'h2, 4'h2, 16'h0030, 0, 0, 1, 1, 1, 0);
    vecs[7]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 1, 1, 1);
    vecs[8]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 1, 1, 2);
    vecs[9]  = mk(4'hF, 4'h0, 16'h0000, 0, 0, 1, 1, 1, 3);
    vecs[10] = mk(4'hF, 4'h4, 16'h0000, 0, 0, 1, 2, 1, 0);
    vecs[11] = mk(4'hF, 4'h8, 16'h0000, 0, 0, 1, 3, 1, 0);
    vecs[12] = mk(4'h0, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(4'h3, 4'h3, 16'h0000, 1, 0, 1, 1, 1, 0);

    // Reset holds every output low even with all threads requesting.
    reset = 1'b0;
    drive(4'hF, 4'hF, 16'h1111, 1'b0, 2'd0);
    #2;
    check_issue("reset", 0, 0, 0, 0);
    check("reset mc_busy", 32'(bus.mc_busy), 32'd0);
    check("reset state", 32'(dbg_state), 32'(ARBITRATE));

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].req, vecs[i].mc, vecs[i].subs, vecs[i].rb_en, vecs[i].rb_idx);
      @(negedge clk);
      check_issue($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_idx, vecs[i].exp_mc, vecs[i].exp_sub);
      next_cycle();
    end

    // Writeback collision: multi-cycle at 10, single-cycle request from 14.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 10)     drive(4'h2, 4'h2, 16'h0000, 0, 0);
      else if (c >= 14) drive(4'h1, 4'h0, 16'h0000, 0, 0);
      else             drive(4'h0, 4'h0, 16'h0000, 0, 0);
      @(negedge clk);
      if (c == 10) check_issue("slot c10", 1, 1, 1, 0);
`ifdef MC_WRITEBACK_RESERVE_EN
      if (c == 14) check_issue("slot c14", 0, 0, 0, 0);
`else
      if (c == 14) check_issue("slot c14", 1, 0, 0, 0);
`endif
      if (c == 15) check_issue("slot c15", 1, 0, 0, 0);
      next_cycle();
    end

    // Rollback of the locked thread at subcycle 2.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       drive(4'h2, 4'h2, 16'h0030, 0, 0);
        1, 3:    drive(4'hF, 4'h0, 16'h0000, 0, 0);
        2:       drive(4'hF, 4'h0, 16'h0000, 1, 1);
        default: drive(4'h0, 4'h0, 16'h0000, 0, 0);
      endcase
      @(negedge clk);
      if (c == 0) check_issue("rb c0", 1, 1, 1, 0);
      if (c == 1) check_issue("rb c1", 1, 1, 1, 1);
      if (c == 2) begin
        check_issue("rb c2", 0, 0, 0, 0);
        check("rb c2 mc_busy", 32'(bus.mc_busy), 32'd1);
        check("rb c2 state", 32'(dbg_state), 32'(SEQUENCE));
      end
      if (c == 3) check_issue("rb c3", 1, 2, 0, 0);
      if (c == 6) check("rb c6 mc_busy", 32'(bus.mc_busy), 32'd1);
      if (c == 7) check("rb c7 mc_busy", 32'(bus.mc_busy), 32'd0);
      next_cycle();
    end

    // Asynchronous reset in the middle of a sequence.
    do_reset();
    drive(4'h4, 4'h4, 16'h0500, 0, 0);
    @(negedge clk);
    check_issue("mid c0", 1, 2, 1, 0);
    next_cycle();
    drive(4'hF, 4'h0, 16'h0000, 0, 0);
    @(negedge clk);
    check_issue("mid c1", 1, 2, 1, 1);
    #2 reset = 1'b0;
    #1;
    check_issue("mid reset", 0, 0, 0, 0);
    check("mid reset mc_busy", 32'(bus.mc_busy), 32'd0);
    check("mid reset state", 32'(dbg_state), 32'(ARBITRATE));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_issue("post reset c0", 1, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    check_issue("post reset c1", 1, 1, 0, 0);
    next_cycle();

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      r_req  = 4'($urandom_range(0, 15));
      r_mc   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      r_subs = '0;
      for (int t = 0; t < NT; t++) r_subs[4*t +: 4] = 4'($urandom_range(0, 3));
      r_rb   = ($urandom_range(0, 7) == 0);
      r_rbi  = 2'($urandom_range(0, 3));
      drive(r_req, r_mc, r_subs, r_rb, r_rbi);
      model_step(c, r_req, r_mc, r_subs, r_rb, r_rbi);
      @(negedge clk);
      e = exp_q.pop_front();
      check_issue($sformatf("rnd%0d", c), e[8], e[7:6], e[5], e[4:1]);
      check($sformatf("rnd%0d mc_busy", c), 32'(bus.mc_busy), 32'(e[0]));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_cycle_issue_arbiter.md
# multi_cycle_issue_arbiter

Chooses which hardware thread issues each cycle and sequences vector multi-cycle (floating-point add/multiply) operations subcycle by subcycle. It sits between the thread-select logic and the single-cycle / multi-cycle execute pipelines. It keeps a writeback-slot reservation shift register so that single-cycle and multi-cycle results never reach writeback in the same cycle.

## Interface
Parameters:
- THREADS, 4, hardware threads per core
- MC_LATENCY, 5, cycles from multi-cycle issue to writeback
- SC_LATENCY, 1, cycles from single-cycle issue to writeback; must be less than MC_LATENCY

Ports:
- clk  input  1  core clock; sole clock domain
- reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- ts_request  input  THREADS  thread has a decoded instruction ready
- ts_multi_cycle  input  THREADS  that instruction uses the multi-cycle pipeline
- ts_subcycles  input  THREADS x $bits(subcycle_t)  subcycle count minus one, per thread
- rollback_en  input  1  rollback of one thread this cycle
- rollback_thread_idx  input  thread_idx_t  thread being rolled back
- issue_valid  output  1  an instruction issues this cycle
- issue_thread_idx  output  thread_idx_t  issuing thread
- issue_multi_cycle  output  1  issue goes to the multi-cycle pipeline
- issue_subcycle  output  subcycle_t  subcycle being issued
- mc_busy  output  1  a multi-cycle operation is still in flight

## Operation
- State register: ARBITRATE or SEQUENCE. Also held: rr_ptr (thread_idx_t), locked thread, subcycle counter, latched subcycle count.
- wb_res[MC_LATENCY:1]: bit k means the writeback slot k cycles ahead is taken.
  - Shifts down one position every cycle.
  - A single-cycle issue sets bit SC_LATENCY of the shifted vector.
  - A multi-cycle issue sets bit MC_LATENCY of the shifted vector.
- mc_pend[MC_LATENCY:1]: same shift behaviour, but set only by multi-cycle issues. mc_busy = OR of mc_pend.
- Eligibility in ARBITRATE: a thread is eligible when all of these hold:
  - ts_request is set for it;
  - it is not the target of rollback_en this cycle;
  - if it is single-cycle, bit SC_LATENCY of (wb_res >> 1) is clear.
  - Multi-cycle threads are never slot-blocked.
- ARBITRATE:
  - Round-robin pick among eligible threads, starting at rr_ptr. Grant is combinational in the same cycle.
  - On a grant, rr_ptr <= winner + 1, wrapping modulo THREADS.
  - Multi-cycle grant with ts_subcycles = 0: single issue with issue_subcycle = 0; stay in ARBITRATE.
  - Multi-cycle grant with ts_subcycles > 0: issue subcycle 0, latch the thread and count, go to SEQUENCE.
- SEQUENCE:
  - Only the locked thread issues, one subcycle per cycle: issue_multi_cycle = 1, issue_subcycle = counter.
  - ts_request is ignored.
  - When counter equals the latched count, issue that final subcycle and return to ARBITRATE in the same cycle.
- Rollback:
  - If it targets the locked thread in SEQUENCE: issue_valid = 0 that cycle and the state returns to ARBITRATE. Existing reservations and mc_pend bits stay set while the pipeline drains.
  - If it targets any other thread: only that thread's request is masked for the cycle.
- No eligible thread: issue_valid = 0. Other issue outputs are 0.

## Timing
- Issue outputs are combinational from the registered state plus the current inputs, so latency is zero. State, counter, rr_ptr, wb_res and mc_pend update on the rising edge of clk.
- Reset assertion forces these values immediately and asynchronously, including mid-SEQUENCE:
  - state = ARBITRATE, rr_ptr = 0, counter = 0, wb_res = 0, mc_pend = 0;
  - all outputs 0.
- First grant is possible in the first clock cycle after reset deasserts.
- Collision example (MC_LATENCY 5, SC_LATENCY 1): a multi-cycle issue at cycle t blocks single-cycle issue at cycle t+4 only.
- mc_busy stays high for MC_LATENCY cycles after the last multi-cycle issue.

## Configuration
- MC_WRITEBACK_RESERVE_EN
  - Defined: wb_res is built and single-cycle eligibility honours it, as described above.
  - Undefined: wb_res is removed and single-cycle threads are never slot-blocked; this suits a writeback stage with separate ports per pipeline. mc_pend and mc_busy remain.

## Structure
- Shared defines/package: thread_idx_t, subcycle_t, THREADS_PER_CORE, and new constants MC_LATENCY and SC_LATENCY, used by the execute stages too.
- One sub-module: rr_arbiter (parameterised width; request, update_en, one-hot grant; owns rr_ptr).

## Test plan
- All four threads request single-cycle continuously -> grants 0,1,2,3,0,1 on consecutive cycles, issue_multi_cycle = 0.
- Thread 1 multi-cycle with ts_subcycles = 3, others requesting -> thread 1 issues subcycles 0,1,2,3 on four consecutive cycles. Thread 2 is granted on the fifth cycle.
- Multi-cycle issue at cycle 10; thread 0 single-cycle request from cycle 14 -> issue_valid = 0 at 14, thread 0 granted at 15.
- Rollback of the locked thread at subcycle 2 -> issue_valid = 0 that cycle, next requester granted the following cycle. mc_busy falls 5 cycles after the subcycle-1 issue.
- Reset asserted mid-SEQUENCE -> all outputs 0 at once. After deassert, with all threads requesting, thread 0 is granted first.
- Build without MC_WRITEBACK_RESERVE_EN, repeat scenario 3 -> thread 0 granted at cycle 14.
